// File: rtl/mantissa_normalizer.sv
// Floating-point mantissa normalizer: leading-one detect, left shift, exponent adjust with subnormal clamp.
// Build option MANTISSA_NORMALIZER_PIPE_EN registers leading-one detection ahead of the shifter (latency 2).
module mantissa_normalizer #(
    parameter int WIDTH     = 24,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mag,
    input  logic [EXP_WIDTH-1:0] in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mant,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_zero,
    output logic                 out_denorm
);
    localparam int SW = $clog2(WIDTH);

    typedef struct packed {
        logic                 zero;
        logic                 denorm;
        logic [EXP_WIDTH-1:0] ex;
        logic [WIDTH-1:0]     mant;
    } norm_t;

    // Shift distance that brings the highest set bit to WIDTH-1 (0 for a zero input).
    function automatic logic [SW-1:0] lead_shift(input logic [WIDTH-1:0] mag);
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) s = SW'(WIDTH - 1 - i);
        end
        return s;
    endfunction

    // Subnormal results stop shifting once the exponent reaches 1, encoded as exponent 0.
    function automatic norm_t normalize(input logic [WIDTH-1:0]     mag,
                                        input logic [EXP_WIDTH-1:0] ex,
                                        input logic [SW-1:0]        s,
                                        input logic                 z);
        norm_t                r;
        logic [EXP_WIDTH-1:0] s_ext;
        logic [EXP_WIDTH-1:0] sub_sh;
        r      = '0;
        s_ext  = EXP_WIDTH'(s);
        sub_sh = '0;
        if (z) begin
            r.zero = 1'b1;
        end else if (ex > s_ext) begin
            r.mant = mag << s;
            r.ex   = ex - s_ext;
        end else begin
            if (ex != '0) sub_sh = ex - EXP_WIDTH'(1);
            r.mant   = mag << sub_sh;
            r.denorm = 1'b1;
        end
        return r;
    endfunction

    logic                 vld_p2;
    logic [WIDTH-1:0]     mant_p2;
    logic [EXP_WIDTH-1:0] exp_p2;
    logic                 zero_p2;
    logic                 denorm_p2;
    logic                 s2_ready;
    logic                 vld_to_p2;
    norm_t                nxt;

    assign s2_ready = !vld_p2 || out_ready;

`ifdef MANTISSA_NORMALIZER_PIPE_EN
    logic                 vld_p1;
    logic                 s1_ready;
    logic [WIDTH-1:0]     mag_p1;
    logic [EXP_WIDTH-1:0] exp_p1;
    logic [SW-1:0]        s_p1;
    logic                 z_p1;

    assign s1_ready = !vld_p1 || s2_ready;
    assign in_ready = s1_ready;

    // Stage p1: capture the beat together with its shift distance and zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else if (s1_ready) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (s1_ready && in_valid) begin
            mag_p1 <= in_mag;
            exp_p1 <= in_exp;
            s_p1   <= lead_shift(in_mag);
            z_p1   <= (in_mag == '0);
        end
    end

    assign nxt       = normalize(mag_p1, exp_p1, s_p1, z_p1);
    assign vld_to_p2 = vld_p1;
`else
    assign in_ready  = s2_ready;
    assign nxt       = normalize(in_mag, in_exp, lead_shift(in_mag), in_mag == '0);
    assign vld_to_p2 = in_valid;
`endif

    // Stage p2: output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            mant_p2   <= '0;
            exp_p2    <= '0;
            zero_p2   <= 1'b0;
            denorm_p2 <= 1'b0;
        end else if (s2_ready) begin
            vld_p2 <= vld_to_p2;
            if (vld_to_p2) begin
                mant_p2   <= nxt.mant;
                exp_p2    <= nxt.ex;
                zero_p2   <= nxt.zero;
                denorm_p2 <= nxt.denorm;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_mant   = mant_p2;
    assign out_exp    = exp_p2;
    assign out_zero   = zero_p2;
    assign out_denorm = denorm_p2;
endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed-vector bench for mantissa_normalizer; latency and capacity follow MANTISSA_NORMALIZER_PIPE_EN.
module tb_mantissa_normalizer;
`ifdef MANTISSA_NORMALIZER_PIPE_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_mag = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_denorm;

    int total = 0;
    int bad   = 0;

    mantissa_normalizer #(.WIDTH(24), .EXP_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
        .out_zero(out_zero), .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic run_one(input string tag, input logic [23:0] mag, input logic [7:0] ex,
                           input logic [23:0] em, input logic [7:0] ee, input logic ez, input logic ed);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mag    = mag;
        in_exp    = ex;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
        chk({tag, "_mant"},   32'(out_mant),   32'(em));
        chk({tag, "_exp"},    32'(out_exp),    32'(ee));
        chk({tag, "_zero"},   32'(out_zero),   32'(ez));
        chk({tag, "_denorm"}, 32'(out_denorm), 32'(ed));
    endtask

    logic [23:0] bm [4] = '{24'h000001, 24'h000100, 24'h400000, 24'h000003};
    logic [23:0] wm [4] = '{24'h800000, 24'h800000, 24'h800000, 24'hC00000};
    logic [7:0]  we [4] = '{8'd7, 8'd15, 8'd29, 8'd8};

    initial begin
        int idx, got, cyc, prev, stale;
        logic acc;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_mant",  32'(out_mant),  32'd0);
        chk("rst_out_flags", {30'd0, out_zero, out_denorm}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("lsb_one",    24'h000001, 8'd100, 24'h800000, 8'd77, 1'b0, 1'b0);
        run_one("already",    24'h800000, 8'd5,   24'h800000, 8'd5,  1'b0, 1'b0);
        run_one("sub_partial",24'h000010, 8'd10,  24'h002000, 8'd0,  1'b0, 1'b1);
        run_one("sub_exp0",   24'h000010, 8'd0,   24'h000010, 8'd0,  1'b0, 1'b1);
        run_one("zero",       24'h000000, 8'd50,  24'h000000, 8'd0,  1'b1, 1'b0);
        run_one("exp_s_p1",   24'h000001, 8'd24,  24'h800000, 8'd1,  1'b0, 1'b0);
        run_one("exp_eq_s",   24'h000001, 8'd23,  24'h400000, 8'd0,  1'b0, 1'b1);
        run_one("exp1_s1",    24'h400000, 8'd1,   24'h400000, 8'd0,  1'b0, 1'b1);
        run_one("mid_bits",   24'h0000A5, 8'd200, 24'hA50000, 8'd184,1'b0, 1'b0);

        // Back-pressure: consumer stalled while four beats are offered.
        idx = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_mag   = bm[idx];
            in_exp   = 8'd30;
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        chk("bp_accepted",  32'(idx),       32'(CAP));
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head_mant", 32'(out_mant),  32'(wm[0]));
        chk("bp_head_exp",  32'(out_exp),   32'(we[0]));
        @(negedge clk);
        chk("bp_hold_mant", 32'(out_mant),  32'(wm[0]));
        chk("bp_hold_exp",  32'(out_exp),   32'(we[0]));

        got  = 0;
        cyc  = 0;
        prev = 0;
        while (got < 4 && cyc < 40) begin
            cyc++;
            if (out_valid) begin
                chk($sformatf("rel_mant%0d", got), 32'(out_mant), 32'(wm[got]));
                chk($sformatf("rel_exp%0d", got),  32'(out_exp),  32'(we[got]));
                if (got > 0) chk($sformatf("rel_gap%0d", got), 32'(cyc - prev), 32'd1);
                prev = cyc;
                got++;
            end
            out_ready = 1'b1;
            if (idx < 4) begin
                in_valid = 1'b1;
                in_mag   = bm[idx];
                in_exp   = 8'd30;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        chk("rel_count", 32'(got), 32'd4);
        in_valid = 1'b0;

        // Reset while a result is held and another beat may be in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mag    = 24'h000000;
        in_exp    = 8'd50;
        @(negedge clk);
        in_mag = 24'h000003;
        in_exp = 8'd40;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_zero",  32'(out_zero),  32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(out_valid), 32'd0);
        chk("mid_rst_mant",   32'(out_mant),  32'd0);
        chk("mid_rst_exp",    32'(out_exp),   32'd0);
        chk("mid_rst_flags",  {30'd0, out_zero, out_denorm}, 32'd0);
        chk("mid_rst_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("post_rst_stale", 32'(stale), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
